// File: rtl/flex_timer_pkg.sv
// Shared types for flex_timer and the serial blocks that drive its start/done/ack handshake.
package flex_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/flex_timer.sv
// Loadable down-counting timer with one-shot / periodic reload and a start/done/ack handshake.
module flex_timer
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    mode,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    expire_flag,
  output logic                    busy,
  output logic                    done,
  input  logic                    ack,
  output logic                    err_flag
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  timer_state_t            state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] period_q, period_d;
  logic                    mode_q, mode_d;
  logic                    expire_q, expire_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Next-state / datapath: rst handled in the register block, then clear > start > tick/ack.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    err_d    = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      // A zero load is rejected in place; a valid start restarts from any state.
      if (load_val == '0) begin
        err_d = 1'b1;
      end else begin
        state_d  = RUN;
        count_d  = load_val;
        period_d = load_val;
        mode_d   = mode;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (count_enable) begin
            if (count_q == CNT_ONE) begin
              expire_d = 1'b1;
              if (mode_q == MODE_PERIODIC) begin
                count_d = period_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        DONE: begin
          if (ack) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Register block: every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count_out   = count_q;
  assign expire_flag = expire_q;
  assign err_flag    = err_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_flex_timer.sv
// Scenario bench for flex_timer: a reference model pushes expected outputs per cycle, tasks pop and compare.
module tb_flex_timer;
  import flex_timer_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, clear, start, mode, count_enable, ack;
  logic [W-1:0] load_val;
  logic [W-1:0] count_out;
  logic         expire_flag, busy, done, err_flag;

  always #5 clk = ~clk;

  flex_timer #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .start        (start),
    .mode         (mode),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_out    (count_out),
    .expire_flag  (expire_flag),
    .busy         (busy),
    .done         (done),
    .ack          (ack),
    .err_flag     (err_flag)
  );

  // Packed as {cnt, expire, busy, done, err}.
  typedef struct packed {
    logic [W-1:0] cnt;
    logic         exp;
    logic         busy;
    logic         done;
    logic         err;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  timer_state_t m_st;
  logic [W-1:0] m_cnt, m_per;
  logic         m_mode;

  function automatic obs_t observe();
    obs_t o;
    o.cnt  = count_out;
    o.exp  = expire_flag;
    o.busy = busy;
    o.done = done;
    o.err  = err_flag;
    return o;
  endfunction

  // Drive one cycle of inputs, push the model's expected post-edge outputs, advance past the edge.
  task automatic step(input logic r, input logic c, input logic s, input logic md,
                      input logic [W-1:0] lv, input logic en, input logic a);
    obs_t e;
    rst = r; clear = c; start = s; mode = md; load_val = lv; count_enable = en; ack = a;
    e = '0;
    if (r) begin
      m_st = IDLE; m_cnt = '0; m_per = '0; m_mode = 1'b0;
    end else if (c) begin
      m_st = IDLE; m_cnt = '0;
    end else if (s && lv == 0) begin
      e.err = 1'b1;
    end else if (s) begin
      m_st = RUN; m_cnt = lv; m_per = lv; m_mode = md;
    end else if (m_st == RUN && en) begin
      if (m_cnt == 1) begin
        e.exp = 1'b1;
        if (m_mode) m_cnt = m_per;
        else begin m_cnt = '0; m_st = DONE; end
      end else begin
        m_cnt = m_cnt - 1'b1;
      end
    end else if (m_st == DONE && a) begin
      m_st = IDLE;
    end
    e.cnt  = m_cnt;
    e.busy = (m_st == RUN);
    e.done = (m_st == DONE);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    step(1, 0, 0, 0, 0, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_init: got %h want %h", got, e); end
    step(0, 0, 1, 0, 4'd5, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_load: got %h want %h", got, e); end
    n_cmp++;
    if (count_out !== 4'd5 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_run5: got cnt=%0d busy=%b want cnt=5 busy=1", count_out, busy);
    end
    step(1, 0, 0, 0, 0, 1, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_midcount: got %h want %h", got, e); end
    n_cmp++;
    if (got !== obs_t'(0)) begin n_bad++; $display("FAIL reset_zero: got %h want 0", got); end
  endtask

  task automatic test_oneshot();
    obs_t got, e;
    int   want[4] = '{3, 2, 1, 0};
    int   expires = 0;
    step(0, 0, 1, MODE_ONESHOT, 4'd3, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL oneshot_start: got %h want %h", got, e); end
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL oneshot_tick%0d: got %h want %h", i, got, e); end
      n_cmp++;
      if (count_out !== want[i]) begin
        n_bad++; $display("FAIL oneshot_cnt%0d: got %0d want %0d", i, count_out, want[i]);
      end
      if (expire_flag) expires++;
    end
    n_cmp++;
    if (expires != 1 || expire_flag !== 1'b1 || done !== 1'b1) begin
      n_bad++; $display("FAIL oneshot_expire: got expires=%0d flag=%b done=%b want 1/1/1", expires, expire_flag, done);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL oneshot_hold%0d: got %h want %h", i, got, e); end
    end
    step(0, 0, 0, 0, 0, 0, 1);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL oneshot_ack: got %h want %h", got, e); end
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL oneshot_idle: got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_periodic();
    obs_t got, e;
    int   last = -1;
    int   hits = 0;
    step(0, 0, 1, MODE_PERIODIC, 4'd4, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL periodic_start: got %h want %h", got, e); end
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0, (i % 2 == 0), 0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL periodic_cyc%0d: got %h want %h", i, got, e); end
      if (expire_flag) begin
        hits++;
        n_cmp++;
        if (count_out !== 4'd4 || busy !== 1'b1 || (last >= 0 && i - last != 8)) begin
          n_bad++; $display("FAIL periodic_expire%0d: got cnt=%0d busy=%b gap=%0d want 4/1/8", i, count_out, busy, i - last);
        end
        last = i;
      end
    end
    n_cmp++;
    if (hits != 4) begin n_bad++; $display("FAIL periodic_count: got %0d expires want 4", hits); end
    step(0, 1, 0, 0, 0, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL periodic_clear: got %h want %h", got, e); end
  endtask

  task automatic test_zero_load();
    obs_t got, e;
    step(0, 0, 1, 0, 4'd0, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL zero_idle: got %h want %h", got, e); end
    n_cmp++;
    if (err_flag !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_idle_err: got err=%b busy=%b want 1/0", err_flag, busy);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e || err_flag !== 1'b0) begin n_bad++; $display("FAIL zero_pulse: got %h want %h", got, e); end
    step(0, 0, 1, 0, 4'd3, 0, 0);
    step(0, 0, 1, 1, 4'd0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? obs_t'(0) : observe();
      e = exp_q.pop_front();
      if (i == 1) begin
        n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL zero_run: got %h want %h", got, e); end
      end
    end
    n_cmp++;
    if (count_out !== 4'd3 || busy !== 1'b1 || err_flag !== 1'b1) begin
      n_bad++; $display("FAIL zero_run_hold: got cnt=%0d busy=%b err=%b want 3/1/1", count_out, busy, err_flag);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL zero_clear: got %h want %h", got, e); end
  endtask

  task automatic test_max_load();
    obs_t got, e;
    int   ticks = 0;
    logic [W-1:0] prev;
    logic seen = 1'b0;
    step(0, 0, 1, MODE_ONESHOT, 4'd15, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL max_start: got %h want %h", got, e); end
    prev = count_out;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      ticks++;
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL max_tick%0d: got %h want %h", i, got, e); end
      n_cmp++;
      if (count_out >= prev) begin
        n_bad++; $display("FAIL max_wrap%0d: got %0d after %0d want smaller", i, count_out, prev);
      end
      prev = count_out;
      seen = expire_flag;
    end
    n_cmp++;
    if (!seen || ticks != 15) begin
      n_bad++; $display("FAIL max_ticks: got %0d ticks seen=%b want 15 ticks", ticks, seen);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL max_ack: got %h want %h", got, e); end
  endtask

  task automatic test_simultaneous();
    obs_t got, e;
    step(0, 0, 1, MODE_ONESHOT, 4'd5, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      if (i == 3) begin
        got = observe(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL simul_at2: got %h want %h", got, e); end
      end
    end
    step(0, 0, 1, MODE_ONESHOT, 4'd7, 1, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL simul_restart: got %h want %h", got, e); end
    n_cmp++;
    if (count_out !== 4'd7) begin n_bad++; $display("FAIL simul_drop: got cnt=%0d want 7", count_out); end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL simul_down%0d: got %h want %h", i, got, e); end
    end
    step(0, 1, 0, 0, 0, 1, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL simul_clear: got %h want %h", got, e); end
    n_cmp++;
    if (count_out !== 4'd0 || expire_flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL simul_noexp: got cnt=%0d exp=%b busy=%b done=%b want 0/0/0/0",
                        count_out, expire_flag, busy, done);
    end
  endtask

  task automatic test_done_start();
    obs_t got, e;
    step(0, 0, 1, MODE_ONESHOT, 4'd1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    got = observe(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL donest_done: got %h want %h", got, e); end
    step(0, 0, 1, MODE_ONESHOT, 4'd2, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL donest_restart: got %h want %h", got, e); end
    n_cmp++;
    if (count_out !== 4'd2 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL donest_state: got cnt=%0d busy=%b done=%b want 2/1/0", count_out, busy, done);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL donest_clear: got %h want %h", got, e); end
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    step(0, 0, 1, MODE_PERIODIC, 4'd1, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL b2b_start: got %h want %h", got, e); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL b2b_tick%0d: got %h want %h", i, got, e); end
      n_cmp++;
      if (expire_flag !== 1'b1 || count_out !== 4'd1) begin
        n_bad++; $display("FAIL b2b_expire%0d: got exp=%b cnt=%0d want 1/1", i, expire_flag, count_out);
      end
    end
    step(0, 1, 0, 0, 0, 0, 0);
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL b2b_clear: got %h want %h", got, e); end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; mode = 1'b0;
    load_val = '0; count_enable = 1'b0; ack = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_zero_load();
    test_max_load();
    test_simultaneous();
    test_done_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
